// File: rtl/fx2_emulation_debug_connector.sv
// FX2 slave-FIFO emulation: EP2 host->FPGA, EP6 FPGA->host,
// plus a stretched system reset driven by rst_n or a host request.
module fx2_emulation_debug_connector #(
    parameter int DEPTH        = 512,
    parameter int RESET_CYCLES = 16
) (
    input  logic        fx2_ifclk,
    input  logic        rst_n,
    inout  wire  [15:0] fx2_fd,
    input  logic        fx2_sloe,
    input  logic        fx2_slrd,
    input  logic        fx2_slwr,
    input  logic        fx2_pktend,
    input  logic [1:0]  fx2_fifoadr,
    output logic        fx2_flaga,
    output logic        fx2_flagb,
    output logic        fx2_flagc,
    output logic        fx2_flagd,
    input  logic [15:0] host_in_data,
    input  logic        host_in_valid,
    output logic        host_in_ready,
    output logic [15:0] host_out_data,
    output logic        host_out_last,
    output logic        host_out_valid,
    input  logic        host_out_ready,
    input  logic        host_rst_req,
    output logic        reset
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [RW-1:0] RST_LOAD = RW'(RESET_CYCLES);

    // ---------------- EP2 (host -> FPGA) ----------------
    logic [15:0]   ep2_mem_q [DEPTH];
    logic [AW-1:0] ep2_wp_q, ep2_wp_d;
    logic [AW-1:0] ep2_rp_q, ep2_rp_d;
    logic [AW:0]   ep2_cnt_q, ep2_cnt_d;
    logic          ep2_empty, ep2_full;
    logic          ep2_push, ep2_pop;
    logic [15:0]   ep2_head;

    assign ep2_empty = (ep2_cnt_q == '0);
    assign ep2_full  = (ep2_cnt_q == FULL_CNT);
    assign ep2_push  = host_in_valid && !ep2_full;
    assign ep2_pop   = !fx2_slrd && (fx2_fifoadr == 2'b00) && !ep2_empty;
    assign ep2_head  = ep2_empty ? 16'h0000 : ep2_mem_q[ep2_rp_q];

    assign fx2_fd = (!fx2_sloe && (fx2_fifoadr == 2'b00)) ? ep2_head : 16'hzzzz;

    // EP2 pointer and occupancy next-state
    always_comb begin
        ep2_wp_d  = ep2_wp_q;
        ep2_rp_d  = ep2_rp_q;
        ep2_cnt_d = ep2_cnt_q;
        if (ep2_push) ep2_wp_d = ep2_wp_q + AW'(1);
        if (ep2_pop)  ep2_rp_d = ep2_rp_q + AW'(1);
        if (ep2_push && !ep2_pop) ep2_cnt_d = ep2_cnt_q + (AW + 1)'(1);
        if (!ep2_push && ep2_pop) ep2_cnt_d = ep2_cnt_q - (AW + 1)'(1);
    end

    // EP2 state registers, cleared by reset
    always_ff @(posedge fx2_ifclk) begin
        if (!rst_n) begin
            ep2_wp_q  <= '0;
            ep2_rp_q  <= '0;
            ep2_cnt_q <= '0;
        end else begin
            ep2_wp_q  <= ep2_wp_d;
            ep2_rp_q  <= ep2_rp_d;
            ep2_cnt_q <= ep2_cnt_d;
        end
    end

    // EP2 storage; contents are don't-care once pointers reset
    always_ff @(posedge fx2_ifclk) begin
        if (ep2_push) ep2_mem_q[ep2_wp_q] <= host_in_data;
    end

    // ---------------- EP6 (FPGA -> host) ----------------
    logic [15:0]    ep6_mem_q [DEPTH];
    logic [DEPTH-1:0] ep6_last_q, ep6_last_d;
    logic [AW-1:0]  ep6_wp_q, ep6_wp_d;
    logic [AW-1:0]  ep6_rp_q, ep6_rp_d;
    logic [AW:0]    ep6_cnt_q, ep6_cnt_d;
    logic           ep6_empty, ep6_full;
    logic           ep6_push, ep6_pop, ep6_pkt;

    assign ep6_empty = (ep6_cnt_q == '0);
    assign ep6_full  = (ep6_cnt_q == FULL_CNT);
    assign ep6_push  = !fx2_slwr && (fx2_fifoadr == 2'b10) && !ep6_full;
    assign ep6_pkt   = !fx2_pktend && (fx2_fifoadr == 2'b10);
    assign ep6_pop   = host_out_ready && !ep6_empty;

    // EP6 pointers, occupancy and packet-end marking
    always_comb begin
        ep6_wp_d   = ep6_wp_q;
        ep6_rp_d   = ep6_rp_q;
        ep6_cnt_d  = ep6_cnt_q;
        ep6_last_d = ep6_last_q;
        if (ep6_push) begin
            ep6_wp_d = ep6_wp_q + AW'(1);
            ep6_last_d[ep6_wp_q] = ep6_pkt;
        end else if (ep6_pkt && !ep6_empty) begin
            // non-empty means the newest word is still unread
            ep6_last_d[ep6_wp_q - AW'(1)] = 1'b1;
        end
        if (ep6_pop) ep6_rp_d = ep6_rp_q + AW'(1);
        if (ep6_push && !ep6_pop) ep6_cnt_d = ep6_cnt_q + (AW + 1)'(1);
        if (!ep6_push && ep6_pop) ep6_cnt_d = ep6_cnt_q - (AW + 1)'(1);
    end

    // EP6 state registers, cleared by reset
    always_ff @(posedge fx2_ifclk) begin
        if (!rst_n) begin
            ep6_wp_q   <= '0;
            ep6_rp_q   <= '0;
            ep6_cnt_q  <= '0;
            ep6_last_q <= '0;
        end else begin
            ep6_wp_q   <= ep6_wp_d;
            ep6_rp_q   <= ep6_rp_d;
            ep6_cnt_q  <= ep6_cnt_d;
            ep6_last_q <= ep6_last_d;
        end
    end

    // EP6 data storage
    always_ff @(posedge fx2_ifclk) begin
        if (ep6_push) ep6_mem_q[ep6_wp_q] <= fx2_fd;
    end

    assign host_out_valid = !ep6_empty;
    assign host_out_data  = ep6_empty ? 16'h0000 : ep6_mem_q[ep6_rp_q];
    assign host_out_last  = !ep6_empty && ep6_last_q[ep6_rp_q];
    assign host_in_ready  = !ep2_full;

    assign fx2_flaga = !ep2_empty;
    assign fx2_flagb = !ep6_full;
    assign fx2_flagc = !ep2_full;
    assign fx2_flagd = !ep6_empty;

    // ---------------- system reset stretcher ----------------
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          reset_q, reset_d;

    // any cause reloads the counter; it then runs down before release
    always_comb begin
        rcnt_d  = rcnt_q;
        reset_d = 1'b0;
        if (!rst_n || host_rst_req) begin
            rcnt_d  = RST_LOAD;
            reset_d = 1'b1;
        end else if (rcnt_q != '0) begin
            rcnt_d  = rcnt_q - RW'(1);
            reset_d = 1'b1;
        end
    end

    // reset output register; rst_n acts through the next-state logic
    always_ff @(posedge fx2_ifclk) begin
        rcnt_q  <= rcnt_d;
        reset_q <= reset_d;
    end

    assign reset = reset_q;

endmodule

// File: tb/tb_fx2_emulation_debug_connector.sv
// Directed bench for fx2_emulation_debug_connector:
// vector table for FIFO traffic plus sequences for fill, reset timing.
module tb_fx2_emulation_debug_connector;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    wire  [15:0] fd;
    logic        fd_en;
    logic [15:0] fd_w;
    logic        sloe, slrd, slwr, pktend;
    logic [1:0]  adr;
    logic        flaga, flagb, flagc, flagd;
    logic [15:0] hin;
    logic        hv, hin_rdy;
    logic [15:0] od;
    logic        ol, ov, hrdy, hrr, rst_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign fd = fd_en ? fd_w : 16'hzzzz;

    fx2_emulation_debug_connector #(.DEPTH(DEPTH), .RESET_CYCLES(16)) dut (
        .fx2_ifclk(clk),
        .rst_n(rst_n),
        .fx2_fd(fd),
        .fx2_sloe(sloe),
        .fx2_slrd(slrd),
        .fx2_slwr(slwr),
        .fx2_pktend(pktend),
        .fx2_fifoadr(adr),
        .fx2_flaga(flaga),
        .fx2_flagb(flagb),
        .fx2_flagc(flagc),
        .fx2_flagd(flagd),
        .host_in_data(hin),
        .host_in_valid(hv),
        .host_in_ready(hin_rdy),
        .host_out_data(od),
        .host_out_last(ol),
        .host_out_valid(ov),
        .host_out_ready(hrdy),
        .host_rst_req(hrr),
        .reset(rst_o)
    );

    typedef struct {
        string       nm;
        logic [1:0]  adr;
        logic        sloe, slrd, slwr, pkt, hv;
        logic [15:0] hin, fdw;
        logic        hrdy;
        logic [3:0]  fl;
        logic        fdc;
        logic [15:0] fde;
        logic        ov;
        logic [15:0] od;
        logic        ol;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string nm, logic [1:0] a, logic oe, logic rd,
                                logic wr, logic pk, logic v, logic [15:0] hi,
                                logic [15:0] fw, logic hr, logic [3:0] fl,
                                logic fc, logic [15:0] fe, logic xv,
                                logic [15:0] xd, logic xl);
        vec_t r;
        r.nm = nm; r.adr = a; r.sloe = oe; r.slrd = rd; r.slwr = wr;
        r.pkt = pk; r.hv = v; r.hin = hi; r.fdw = fw; r.hrdy = hr;
        r.fl = fl; r.fdc = fc; r.fde = fe; r.ov = xv; r.od = xd; r.ol = xl;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle();
        sloe = 1'b1; slrd = 1'b1; slwr = 1'b1; pktend = 1'b1;
        adr = 2'b11; hv = 1'b0; hin = 16'h0; hrdy = 1'b0;
        fd_w = 16'h0; fd_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_fd(input logic [15:0] w);
        fd_w = w;
        fd_en = sloe || (adr != 2'b00);
    endtask

    task automatic chk_idle_state(input string nm);
        chk({nm, "_flags"}, {28'h0, flaga, flagb, flagc, flagd}, 32'h6);
        chk({nm, "_hin_rdy"}, {31'h0, hin_rdy}, 32'h1);
        chk({nm, "_out"}, {14'h0, ov, ol, od}, 32'h0);
    endtask

    initial begin
        int n;
        int bad;
        idle();
        rst_n = 1'b0;
        hrr = 1'b0;

        // reset state
        repeat (3) step();
        chk_idle_state("rst");
        chk("rst_reset", {31'h0, rst_o}, 32'h1);

        // reset stretch after rst_n release
        @(negedge clk) rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (rst_o) n++;
            else break;
        end
        chk("rel_stretch", n, 16);

        // one-cycle host reset request
        @(negedge clk) hrr = 1'b1;
        step();
        n = rst_o ? 1 : 0;
        @(negedge clk) hrr = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (rst_o) n++;
            else break;
        end
        chk("hreq_stretch", n, 17);

        // name, adr, sloe, slrd, slwr, pkt, hv, hin, fdw, hrdy,
        // flags abcd, fdchk, fd_exp, ov, od, ol
        vq.push_back(mk("push1",  2'b11,1,1,1,1,1,16'hA001,0,0,4'b1110,0,0,0,0,0));
        vq.push_back(mk("push2",  2'b11,1,1,1,1,1,16'hA002,0,0,4'b1110,0,0,0,0,0));
        vq.push_back(mk("push3",  2'b11,1,1,1,1,1,16'hA003,0,0,4'b1110,0,0,0,0,0));
        vq.push_back(mk("rd_adr01",2'b01,1,0,1,1,0,0,0,0,4'b1110,0,0,0,0,0));
        vq.push_back(mk("oe_head",2'b00,0,1,1,1,0,0,0,0,4'b1110,1,16'hA001,0,0,0));
        vq.push_back(mk("pop1",   2'b00,0,0,1,1,0,0,0,0,4'b1110,1,16'hA002,0,0,0));
        vq.push_back(mk("pop2",   2'b00,0,0,1,1,0,0,0,0,4'b1110,1,16'hA003,0,0,0));
        vq.push_back(mk("pop3",   2'b00,0,0,1,1,0,0,0,0,4'b0110,1,16'h0000,0,0,0));
        vq.push_back(mk("pop_emp",2'b00,0,0,1,1,0,0,0,0,4'b0110,1,16'h0000,0,0,0));
        vq.push_back(mk("zlp",    2'b10,1,1,1,0,0,0,0,0,4'b0110,0,0,0,0,0));
        vq.push_back(mk("wr1234", 2'b10,1,1,0,1,0,0,16'h1234,0,4'b0111,0,0,1,16'h1234,0));
        vq.push_back(mk("wr5678", 2'b10,1,1,0,1,0,0,16'h5678,0,4'b0111,0,0,1,16'h1234,0));
        vq.push_back(mk("pktend", 2'b10,1,1,1,0,0,0,0,0,4'b0111,0,0,1,16'h1234,0));
        vq.push_back(mk("get1234",2'b11,1,1,1,1,0,0,0,1,4'b0111,0,0,1,16'h5678,1));
        vq.push_back(mk("get5678",2'b11,1,1,1,1,0,0,0,1,4'b0110,0,0,0,0,0));
        vq.push_back(mk("wr_pkt", 2'b10,1,1,0,0,0,0,16'hBEEF,0,4'b0111,0,0,1,16'hBEEF,1));
        vq.push_back(mk("getBEEF",2'b11,1,1,1,1,0,0,0,1,4'b0110,0,0,0,0,0));
        vq.push_back(mk("pushC1", 2'b11,1,1,1,1,1,16'hC001,0,0,4'b1110,0,0,0,0,0));
        vq.push_back(mk("pp_ep2", 2'b00,0,0,1,1,1,16'hC002,0,0,4'b1110,1,16'hC002,0,0,0));
        vq.push_back(mk("popC2",  2'b00,0,0,1,1,0,0,0,0,4'b0110,1,16'h0000,0,0,0));
        vq.push_back(mk("wr1111", 2'b10,1,1,0,1,0,0,16'h1111,0,4'b0111,0,0,1,16'h1111,0));
        vq.push_back(mk("pp_ep6", 2'b10,1,1,0,1,0,0,16'h2222,1,4'b0111,0,0,1,16'h2222,0));
        vq.push_back(mk("get2222",2'b11,1,1,1,1,0,0,0,1,4'b0110,0,0,0,0,0));
        vq.push_back(mk("wr3333", 2'b10,1,1,0,1,0,0,16'h3333,0,4'b0111,0,0,1,16'h3333,0));
        vq.push_back(mk("get3333",2'b11,1,1,1,1,0,0,0,1,4'b0110,0,0,0,0,0));
        vq.push_back(mk("pkt_rd", 2'b10,1,1,1,0,0,0,0,0,4'b0110,0,0,0,0,0));
        vq.push_back(mk("wr4444", 2'b10,1,1,0,1,0,0,16'h4444,0,4'b0111,0,0,1,16'h4444,0));
        vq.push_back(mk("get4444",2'b11,1,1,1,1,0,0,0,1,4'b0110,0,0,0,0,0));

        foreach (vq[i]) begin
            @(negedge clk);
            adr = vq[i].adr; sloe = vq[i].sloe; slrd = vq[i].slrd;
            slwr = vq[i].slwr; pktend = vq[i].pkt; hv = vq[i].hv;
            hin = vq[i].hin; hrdy = vq[i].hrdy;
            drv_fd(vq[i].fdw);
            step();
            chk({vq[i].nm, "_flags"}, {28'h0, flaga, flagb, flagc, flagd},
                {28'h0, vq[i].fl});
            chk({vq[i].nm, "_hin_rdy"}, {31'h0, hin_rdy}, 32'h1);
            chk({vq[i].nm, "_out"}, {14'h0, ov, ol, od},
                {14'h0, vq[i].ov, vq[i].ol, vq[i].od});
            if (vq[i].fdc) chk({vq[i].nm, "_fd"}, {16'h0, fd}, {16'h0, vq[i].fde});
        end
        @(negedge clk) idle();

        // fill EP6 to DEPTH with no consumer
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            adr = 2'b10; slwr = 1'b0;
            drv_fd(16'(i));
            step();
            if (i == DEPTH - 2) chk("fill_b_nf", {31'h0, flagb}, 32'h1);
            if (i == DEPTH - 1) chk("fill_b_full", {31'h0, flagb}, 32'h0);
        end
        @(negedge clk) drv_fd(16'hDEAD);
        step();
        chk("drop_b", {31'h0, flagb}, 32'h0);
        chk("drop_head", {16'h0, od}, 32'h0);
        @(negedge clk);
        idle();
        hrdy = 1'b1;
        step();
        chk("pop1_b", {31'h0, flagb}, 32'h1);
        chk("pop1_head", {16'h0, od}, 32'h1);
        bad = 0;
        for (int j = 1; j < DEPTH; j++) begin
            if (!ov || od != 16'(j) || ol) bad++;
            step();
        end
        chk("drain_seq", bad, 0);
        chk("drain_empty", {31'h0, ov}, 32'h0);

        // reset in the middle of buffered traffic
        @(negedge clk);
        idle();
        hv = 1'b1; hin = 16'h7777;
        adr = 2'b10; slwr = 1'b0;
        drv_fd(16'h8888);
        step();
        step();
        chk("pre_rst_flags", {28'h0, flaga, flagb, flagc, flagd}, 32'hF);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        step();
        chk_idle_state("mid_rst");
        chk("mid_rst_reset", {31'h0, rst_o}, 32'h1);
        @(negedge clk);
        sloe = 1'b0; adr = 2'b00;
        #1;
        chk("mid_rst_fd", {16'h0, fd}, 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        step();
        chk_idle_state("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fx2_emulation_debug_connector.md
FX2_EMULATION_DEBUG_CONNECTOR -- requirements
Module: fx2_emulation_debug_connector

Interface
REQ-001 Parameter DEPTH, default 512, SHALL set the word depth of each endpoint FIFO and SHALL be a power of two, minimum 4.
REQ-002 Parameter RESET_CYCLES, default 16, SHALL set the number of cycles the system reset output stays asserted after a reset cause ends.
REQ-003 fx2_ifclk  in  1  SHALL be the single clock for all logic; all state SHALL change on its rising edge only.
REQ-004 rst_n  in  1  SHALL be a synchronous, active-low reset.
REQ-005 fx2_fd  inout  16  SHALL be the FX2 slave-FIFO data bus.
REQ-006 fx2_sloe, fx2_slrd, fx2_slwr, fx2_pktend  in  1 each  SHALL be active-low FX2 strobes (output enable, read, write, packet end).
REQ-007 fx2_fifoadr  in  2  SHALL select the endpoint: 2'b00 = EP2 (host-to-FPGA); 2'b10 = EP6 (FPGA-to-host); other values SHALL select nothing.
REQ-008 fx2_flaga / fx2_flagb / fx2_flagc / fx2_flagd  out  1 each  SHALL mean EP2 empty_n / EP6 full_n / EP2 full_n / EP6 empty_n.
REQ-009 host_in_data  in  16, host_in_valid  in  1, host_in_ready  out  1  SHALL form the host stream into EP2.
REQ-010 host_out_data  out  16, host_out_last  out  1, host_out_valid  out  1, host_out_ready  in  1  SHALL form the stream from EP6 to the host.
REQ-011 host_rst_req  in  1  SHALL be an active-high host request to reset the system.
REQ-012 reset  out  1  SHALL be the active-high system reset.

Function
REQ-013 Each endpoint SHALL be a synchronous FIFO of DEPTH entries, with an occupancy counter of width log2(DEPTH)+1 and read/write pointers that wrap modulo DEPTH.
REQ-014 host_in_ready SHALL equal EP2 not full; a word SHALL be pushed to EP2 on a rising edge with host_in_valid && host_in_ready.
REQ-015 EP2 SHALL be first-word-fall-through.
REQ-016 While fx2_sloe==0 and fx2_fifoadr==2'b00, fx2_fd SHALL drive the EP2 head word, or 16'h0000 if EP2 is empty; otherwise fx2_fd SHALL be high-Z.
REQ-017 A rising edge with fx2_slrd==0, fx2_fifoadr==2'b00 and EP2 not empty SHALL pop one EP2 word; a read while empty SHALL be ignored.
REQ-018 A rising edge with fx2_slwr==0, fx2_fifoadr==2'b10 and EP6 not full SHALL push fx2_fd into EP6 with last=0; a write while full SHALL be dropped.
REQ-019 A rising edge with fx2_pktend==0 and fx2_fifoadr==2'b10 SHALL set last=1 on the most recently written EP6 word, if that word is still unread.
REQ-020 A rising edge with fx2_pktend==0 and fx2_slwr==0 together SHALL store the written word with last=1.
REQ-021 A pktend with EP6 empty (zero-length packet) SHALL be ignored.
REQ-022 host_out_valid SHALL equal EP6 not empty; host_out_data and host_out_last SHALL show the EP6 head word.
REQ-023 An EP6 word SHALL be popped on a rising edge with host_out_valid && host_out_ready.
REQ-024 A simultaneous push and pop on the same FIFO SHALL leave its occupancy unchanged, and both operations SHALL take effect.
REQ-025 All flags SHALL be combinational from the registered occupancy counters, so a push or pop is visible on the flags in the cycle after the edge.
REQ-026 A FIFO is full when occupancy == DEPTH and empty when occupancy == 0.
REQ-027 reset SHALL be 1 while rst_n==0 or host_rst_req==1, and SHALL then stay 1 for exactly RESET_CYCLES further rising edges, driven by a down-counter reloaded on every cause.
REQ-028 reset SHALL be registered.

Reset
REQ-029 With rst_n==0 at a rising edge, both FIFOs SHALL be emptied, pointers and last bits SHALL be cleared, and the reset counter SHALL be loaded with RESET_CYCLES.
REQ-030 While in reset: fx2_flaga=0, fx2_flagb=1, fx2_flagc=1, fx2_flagd=0, host_in_ready=1, host_out_valid=0, host_out_last=0, host_out_data=16'h0000, reset=1, and fx2_fd SHALL follow REQ-016.
REQ-031 A reset applied mid-transfer SHALL discard all buffered data.

Verification
REQ-032 Push 3 host words 16'hA001..A003; with fifoadr=00 and sloe=0, pulse slrd for 3 cycles -> fd shows A001, A002, A003 in order; flaga becomes 0 after the third pop.
REQ-033 With fifoadr=10, write 16'h1234 then 16'h5678, then pulse pktend -> host_out delivers 1234 (last=0), then 5678 (last=1); flagd then returns to 0.
REQ-034 Write DEPTH words into EP6 with host_out_ready=0 -> flagb=0 after the last write; a further write is dropped; after one pop, flagb=1.
REQ-035 Pulse slrd with EP2 empty, and assert pktend with EP6 empty -> no state change, no host_out_valid.
REQ-036 Release rst_n -> reset stays 1 for 16 more cycles and then goes 0; a 1-cycle host_rst_req pulse -> reset is 1 for 17 cycles.
REQ-037 Same-edge push and pop on EP2 holding 1 word -> occupancy stays 1 and the new word becomes the head.
